div_unit: RTL and testbench
===========================

# div_unit

Iterative 32-bit integer divider implementing RV32M DIV, DIVU, REM and REMU. It sits beside the combinational ALU in the execute stage. The core issues a request over a valid/ready handshake; the unit runs a radix-2 restoring division, one quotient bit per cycle, and returns the result over a second valid/ready handshake. Divide-by-zero and signed overflow bypass the iteration and respond in one cycle.

## Interface
- `WIDTH`, default 32: operand and result width.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `reqValid`  in  1  request present on `op`, `A`, `B`.
- `reqReady`  out  1  unit can accept a request. High only in IDLE.
- `op`  in  2  operation select: 00 DIV, 01 DIVU, 10 REM, 11 REMU.
- `A`  in  WIDTH  dividend.
- `B`  in  WIDTH  divisor.
- `respValid`  out  1  `out` holds a completed result.
- `respReady`  in  1  consumer accepts the result.
- `out`  out  WIDTH  quotient (DIV/DIVU) or remainder (REM/REMU).

## Operation
- States are IDLE, CALC and DONE. Reset forces IDLE, with `reqReady`=1, `respValid`=0, `out`=0, and the iteration counter at 0.
- **IDLE**
  - On `reqValid && reqReady`, latch `op`, `A` and `B`. `A`, `B` and `op` are not sampled at any other time.
  - Divide by zero (`B`==0) goes to DONE with a result of all-ones for DIV/DIVU, or `A` for REM/REMU.
  - Signed overflow (DIV/REM, `A`==0x80000000, `B`==0xFFFFFFFF) goes to DONE with a result of 0x80000000 for DIV, or 0 for REM.
  - All other requests go to CALC.
- **CALC**
  - Signed ops first convert the operands to magnitudes (two's-complement absolute value).
  - Each cycle:
    - shift the remainder register left by 1, bringing in the next dividend MSB;
    - if remainder ≥ divisor magnitude, subtract it and shift in quotient bit 1, otherwise shift in 0.
  - Exactly WIDTH iterations run, then the unit moves to DONE.
  - Sign fix-up for signed ops:
    - the quotient is negated if the signs of `A` and `B` differ;
    - the remainder is negated if `A` is negative (the remainder takes the sign of the dividend).
  - Unsigned ops use the raw magnitudes.
  - Invariant: for signed ops, `A` = q*`B` + r, with |r| < |`B`|.
- **DONE**
  - `respValid`=1 and `out` is registered and stable.
  - On `respReady`, the unit goes to IDLE and `respValid` drops on the next edge.
  - While `respReady`=0, `respValid` and `out` hold indefinitely.
- `reqReady` is a decode of the registered state. A request therefore cannot be accepted in the cycle a response is consumed; it is accepted one cycle later at the earliest.
- Inputs are ignored outside IDLE. `reqValid` asserted during CALC/DONE has no effect.
- All arithmetic is modulo 2^WIDTH. The remainder register is WIDTH+1 bits, so the compare/subtract cannot overflow.

## Timing
- Request accepted at rising edge T.
  - Normal path: CALC occupies cycles T+1 … T+WIDTH, and `respValid` is high from T+WIDTH+1 (33 cycles after acceptance for WIDTH=32).
  - Bypass path (div-by-zero, overflow): `respValid` is high from T+1.
- With `respReady` already high, the response is consumed at the first edge where `respValid`=1, and `reqReady` returns high in the following cycle.
- Throughput is at most one operation per WIDTH+2 cycles.
- Asserting `rst_n` low in any state immediately (asynchronously) clears `respValid` to 0 and `reqReady` to IDLE value 1. The in-flight operation is discarded, and no response is ever produced for it.
- Once `respValid`=1, `out` changes only after the response is consumed.

## Test plan
- DIVU A=100, B=7 → `out`=14, with `respValid` rising exactly 33 cycles after acceptance. REMU with the same operands → 2.
- DIV A=0xFFFFFFF9 (−7), B=2 → 0xFFFFFFFD (−3). REM with the same operands → 0xFFFFFFFF (−1). DIV A=7, B=0xFFFFFFFE → 0xFFFFFFFD.
- Divide by zero, A=0x12345678, B=0:
  - DIVU and DIV → 0xFFFFFFFF;
  - REMU and REM → 0x12345678;
  - every case responds at T+1.
- Overflow, A=0x80000000, B=0xFFFFFFFF: DIV → 0x80000000, REM → 0, both responding at T+1. DIVU with the same operands → 0 after 33 cycles.
- Backpressure: hold `respReady`=0 for 10 cycles after `respValid`.
  - `out` must stay stable and `reqReady` must stay low.
  - A `reqValid` pulse with new operands during CALC must be ignored.
  - After release, the next request is accepted no earlier than one cycle after consumption.
- Reset mid-CALC: assert `rst_n`=0 at iteration 10 → `respValid`=0 and `reqReady`=1 immediately. After release, DIVU 1000/10 → 100.
- Random fuzz over 10^5 requests, with signed and unsigned results checked against a reference model: `A` = q*`B` + r, and |r| < |`B`|.

Source files
------------

// File: rtl/div_unit.sv
// ---------------------------------------------------------------------------
// div_unit
//
// Iterative integer divider for RV32M DIV / DIVU / REM / REMU. A radix-2
// restoring divider produces one quotient bit per cycle, so a normal
// operation spends WIDTH cycles in CALC. Divide-by-zero and signed overflow
// skip the iteration and go straight to DONE.
//
// Ports
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   reqValid   in   request present on op / A / B
//   reqReady   out  unit can accept a request (high only in IDLE)
//   op         in   00 DIV, 01 DIVU, 10 REM, 11 REMU
//   A          in   dividend
//   B          in   divisor
//   respValid  out  out holds a completed result (high only in DONE)
//   respReady  in   consumer accepts the result
//   out        out  quotient (DIV/DIVU) or remainder (REM/REMU)
// ---------------------------------------------------------------------------
module div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             reqValid,
    output logic             reqReady,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             respValid,
    input  logic             respReady,
    output logic [WIDTH-1:0] out
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [CW-1:0]    count;
    logic             is_rem;     // result is the remainder
    logic             neg_q;      // quotient needs negating at the end
    logic             neg_r;      // remainder needs negating at the end
    logic [WIDTH:0]   rem;        // partial remainder, one spare bit
    logic [WIDTH-1:0] quo;        // dividend shifts out, quotient shifts in
    logic [WIDTH-1:0] dvs;        // divisor magnitude
    logic [WIDTH-1:0] out_r;

    // Request decode, only meaningful in IDLE.
    logic             req_signed;
    logic             req_rem;
    logic             div_zero;
    logic             overflow;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;

    // One iteration step and the sign-corrected final results.
    logic [WIDTH:0]   rem_shift;
    logic             take;
    logic [WIDTH:0]   rem_next;
    logic [WIDTH-1:0] quo_next;
    logic [WIDTH-1:0] q_final;
    logic [WIDTH-1:0] r_final;

    // NOTE: every signal assigned in always_comb gets a default first, so no
    // path can leave it unassigned and infer a latch.
    always_comb begin
        req_signed = ~op[0];
        req_rem    = op[1];
        div_zero   = (B == '0);
        overflow   = req_signed && (A == MIN_NEG) && (B == ALL_ONES);
        a_mag      = (req_signed && A[WIDTH-1]) ? -A : A;
        b_mag      = (req_signed && B[WIDTH-1]) ? -B : B;

        // Bring the next dividend MSB into the partial remainder.
        rem_shift  = {rem[WIDTH-1:0], quo[WIDTH-1]};
        take       = (rem_shift >= {1'b0, dvs});
        rem_next   = take ? (rem_shift - {1'b0, dvs}) : rem_shift;
        quo_next   = {quo[WIDTH-2:0], take};

        q_final    = neg_q ? -quo_next : quo_next;
        r_final    = neg_r ? -rem_next[WIDTH-1:0] : rem_next[WIDTH-1:0];
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            count  <= '0;
            is_rem <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            rem    <= '0;
            quo    <= '0;
            dvs    <= '0;
            out_r  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (reqValid) begin
                        is_rem <= req_rem;
                        count  <= '0;
                        if (div_zero) begin
                            out_r <= req_rem ? A : ALL_ONES;
                            state <= DONE;
                        end else if (overflow) begin
                            out_r <= req_rem ? '0 : MIN_NEG;
                            state <= DONE;
                        end else begin
                            neg_q <= req_signed && (A[WIDTH-1] ^ B[WIDTH-1]);
                            neg_r <= req_signed && A[WIDTH-1];
                            rem   <= '0;
                            quo   <= a_mag;
                            dvs   <= b_mag;
                            state <= CALC;
                        end
                    end
                end
                CALC: begin
                    rem   <= rem_next;
                    quo   <= quo_next;
                    count <= count + CW'(1);
                    // The last step writes the fixed-up result directly so
                    // DONE starts with a stable registered output.
                    if (count == LAST_ITER) begin
                        out_r <= is_rem ? r_final : q_final;
                        count <= '0;
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (respReady) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Decodes of the registered state; reset reaches them asynchronously.
    assign reqReady  = (state == IDLE);
    assign respValid = (state == DONE);
    assign out       = out_r;

endmodule

// File: tb/tb_div_unit.sv
// ---------------------------------------------------------------------------
// tb_div_unit
//
// Directed checks of div_unit: reset state, quotient/remainder values for
// signed and unsigned ops, response latency, bypass paths, backpressure,
// reset during iteration, and a short randomised sweep against a model.
// ---------------------------------------------------------------------------
module tb_div_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        reqValid = 1'b0;
    logic        reqReady;
    logic [1:0]  op = 2'd0;
    logic [31:0] A = '0;
    logic [31:0] B = '0;
    logic        respValid;
    logic        respReady = 1'b1;
    logic [31:0] out;

    int n_vec = 0;
    int n_err = 0;

    localparam logic [1:0] OP_DIV  = 2'd0;
    localparam logic [1:0] OP_DIVU = 2'd1;
    localparam logic [1:0] OP_REM  = 2'd2;
    localparam logic [1:0] OP_REMU = 2'd3;

    always #5 clk = ~clk;

    div_unit #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .reqValid  (reqValid),
        .reqReady  (reqReady),
        .op        (op),
        .A         (A),
        .B         (B),
        .respValid (respValid),
        .respReady (respReady),
        .out       (out)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Issue one request and wait for its response. cyc is 1 when respValid is
    // seen right after the accepting edge, WIDTH+1 for a full iteration.
    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] res, output int cyc);
        int guard;
        guard = 0;
        @(negedge clk);
        while (!reqReady && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        op = o;
        A = a;
        B = b;
        reqValid = 1'b1;
        @(posedge clk);
        #1 reqValid = 1'b0;
        cyc = 1;
        @(negedge clk);
        while (!respValid && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        res = out;
    endtask

    typedef struct {
        string       tag;
        logic [1:0]  o;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          cyc;
    } vec_t;

    vec_t vecs[$];

    initial begin
        logic [31:0] res;
        logic [31:0] held;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        logic [1:0]  o;
        int          cyc;
        int          guard;
        int          sa;
        int          sb;
        bit          spurious;

        vecs.push_back('{"divu_100_7",   OP_DIVU, 32'd100,        32'd7,          32'd14,         33});
        vecs.push_back('{"remu_100_7",   OP_REMU, 32'd100,        32'd7,          32'd2,          33});
        vecs.push_back('{"div_m7_2",     OP_DIV,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  33});
        vecs.push_back('{"rem_m7_2",     OP_REM,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  33});
        vecs.push_back('{"div_7_m2",     OP_DIV,  32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  33});
        vecs.push_back('{"rem_7_m2",     OP_REM,  32'd7,          32'hFFFF_FFFE,  32'd1,          33});
        vecs.push_back('{"divu_zero",    OP_DIVU, 32'h1234_5678,  32'd0,          32'hFFFF_FFFF,  1});
        vecs.push_back('{"div_zero",     OP_DIV,  32'h1234_5678,  32'd0,          32'hFFFF_FFFF,  1});
        vecs.push_back('{"remu_zero",    OP_REMU, 32'h1234_5678,  32'd0,          32'h1234_5678,  1});
        vecs.push_back('{"rem_zero",     OP_REM,  32'h1234_5678,  32'd0,          32'h1234_5678,  1});
        vecs.push_back('{"div_ovf",      OP_DIV,  32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  1});
        vecs.push_back('{"rem_ovf",      OP_REM,  32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          1});
        vecs.push_back('{"divu_ovf_ops", OP_DIVU, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          33});
        vecs.push_back('{"remu_ovf_ops", OP_REMU, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  33});
        vecs.push_back('{"divu_max_1",   OP_DIVU, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  33});
        vecs.push_back('{"div_min_2",    OP_DIV,  32'h8000_0000,  32'd2,          32'hC000_0000,  33});
        vecs.push_back('{"rem_m100_m7",  OP_REM,  32'hFFFF_FF9C,  32'hFFFF_FFF9,  32'hFFFF_FFFE,  33});

        // Reset state.
        #12;
        check("rst_reqReady",  {31'd0, reqReady},  32'd1);
        check("rst_respValid", {31'd0, respValid}, 32'd0);
        check("rst_out",       out,                32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed vectors, consumer always ready.
        foreach (vecs[i]) begin
            run_op(vecs[i].o, vecs[i].a, vecs[i].b, res, cyc);
            check({vecs[i].tag, "_out"}, res, vecs[i].exp);
            check({vecs[i].tag, "_lat"}, cyc, vecs[i].cyc);
        end

        // Response consumed at the next edge; reqReady back the cycle after.
        @(negedge clk);
        check("consume_respValid", {31'd0, respValid}, 32'd0);
        check("consume_reqReady",  {31'd0, reqReady},  32'd1);

        // Backpressure with an ignored request pulse during CALC.
        respReady = 1'b0;
        @(negedge clk);
        op = OP_DIVU; A = 32'd100; B = 32'd7; reqValid = 1'b1;
        @(posedge clk);
        #1 reqValid = 1'b0;
        repeat (5) @(negedge clk);
        op = OP_DIVU; A = 32'd5; B = 32'd1; reqValid = 1'b1;
        check("bp_calc_reqReady", {31'd0, reqReady}, 32'd0);
        @(negedge clk);
        reqValid = 1'b0;
        guard = 0;
        while (!respValid && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        check("bp_respValid", {31'd0, respValid}, 32'd1);
        check("bp_out", out, 32'd14);
        held = out;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("bp_hold_out",       out,                 held);
            check("bp_hold_respValid", {31'd0, respValid},  32'd1);
            check("bp_hold_reqReady",  {31'd0, reqReady},   32'd0);
        end
        // Release and present a new request in the same cycle.
        respReady = 1'b1;
        op = OP_DIVU; A = 32'd1000; B = 32'd10; reqValid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("bp_release_respValid", {31'd0, respValid}, 32'd0);
        check("bp_release_reqReady",  {31'd0, reqReady},  32'd1);
        @(posedge clk);
        #1 reqValid = 1'b0;
        cyc = 1;
        @(negedge clk);
        while (!respValid && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        check("bp_next_out", out, 32'd100);
        check("bp_next_lat", cyc, 33);

        // Reset during iteration 10.
        @(negedge clk);
        op = OP_DIVU; A = 32'hFFFF_FFFF; B = 32'd3; reqValid = 1'b1;
        @(posedge clk);
        #1 reqValid = 1'b0;
        repeat (10) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_respValid", {31'd0, respValid}, 32'd0);
        check("midrst_reqReady",  {31'd0, reqReady},  32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        spurious = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (respValid) spurious = 1'b1;
        end
        check("midrst_no_resp", {31'd0, spurious}, 32'd0);
        run_op(OP_DIVU, 32'd1000, 32'd10, res, cyc);
        check("midrst_after_out", res, 32'd100);
        check("midrst_after_lat", cyc, 33);

        // Short randomised sweep against the language's own division.
        for (int i = 0; i < 40; i++) begin
            o = 2'($urandom_range(3, 0));
            a = $urandom;
            b = $urandom;
            if (i % 2 == 1) b = b >> $urandom_range(31, 0);
            if (b == '0) b = 32'd1;
            if (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) b = 32'd3;
            sa = a;
            sb = b;
            case (o)
                OP_DIV:  exp = sa / sb;
                OP_DIVU: exp = a / b;
                OP_REM:  exp = sa % sb;
                default: exp = a % b;
            endcase
            run_op(o, a, b, res, cyc);
            check("rand_out", res, exp);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
